io_wr_arbiter: RTL and testbench

IO_WR_ARBITER -- requirements
Module: io_wr_arbiter

---
 rtl/io_wr_arbiter_pkg.sv | 15 +
 rtl/io_wr_arbiter_rr_pick.sv | 26 ++
 rtl/io_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_io_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_wr_arbiter_pkg.sv
// Shared defaults and FSM state type for the IO write arbiter slice.
package io_wr_arbiter_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_IO_ADDR_WIDTH = 16;
  localparam int DEF_IO_DATA_WIDTH = 256;
  localparam int DEF_MAX_BURST     = 8;
  localparam int DEF_STALL_LIMIT   = 15;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/io_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_wr_arbiter.sv
// Burst-locking round-robin arbiter that merges requester writes onto one
// registered IO write port, with burst cap and stall-abort release.
module io_wr_arbiter
  import io_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int IO_ADDR_WIDTH = DEF_IO_ADDR_WIDTH,
  parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter int MAX_BURST     = DEF_MAX_BURST,
  parameter int STALL_LIMIT   = DEF_STALL_LIMIT,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0]                     req_last,
  input  logic [NUM_REQ-1:0][IO_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][IO_DATA_WIDTH-1:0]  req_data,
  output logic                                   io_en_out,
  output logic [IO_ADDR_WIDTH-1:0]               io_addr_out,
  output logic [IO_DATA_WIDTH-1:0]               io_data_out,
  output logic [IW-1:0]                          grant_id,
  output logic                                   abort_pulse
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam bit SINGLE_BEAT = (MAX_BURST == 1);

  arb_state_e        state, state_nx;
  logic [IW-1:0]     last_owner, ptr, pick_idx, xfer_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic              pick_any;
  logic [BW-1:0]     beat_cnt, beat_nx;
  logic [SW-1:0]     stall_cnt, stall_nx;
  logic              xfer, stall_hit;

  // In LOCKED the owner is last_owner, so the search always starts one past it.
  always_comb begin
    if (last_owner == IW'(NUM_REQ - 1)) ptr = '0;
    else                                ptr = last_owner + IW'(1);
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    beat_nx   = beat_cnt;
    stall_nx  = stall_cnt;
    xfer      = 1'b0;
    xfer_idx  = last_owner;
    stall_hit = 1'b0;
    case (state)
      ARB_IDLE: begin
        beat_nx  = '0;
        stall_nx = '0;
        if (pick_any) begin
          xfer     = 1'b1;
          xfer_idx = pick_idx;
          if (!req_last[pick_idx] && !SINGLE_BEAT) begin
            state_nx = ARB_LOCKED;
            beat_nx  = BW'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (req_valid[last_owner]) begin
          xfer     = 1'b1;
          stall_nx = '0;
          beat_nx  = beat_cnt + BW'(1);
          if (req_last[last_owner] || beat_cnt == BW'(MAX_BURST - 1)) begin
            state_nx = ARB_IDLE;
            beat_nx  = '0;
          end
        end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
          stall_hit = 1'b1;
          state_nx  = ARB_IDLE;
          stall_nx  = '0;
          beat_nx   = '0;
        end else begin
          stall_nx = stall_cnt + SW'(1);
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Ready never looks at last/addr/data so requesters can build them late.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      case (state)
        ARB_IDLE:   req_ready = pick_grant;
        ARB_LOCKED: req_ready[last_owner] = req_valid[last_owner];
        default:    req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner  <= IW'(NUM_REQ - 1);
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      io_en_out   <= 1'b0;
      io_addr_out <= '0;
      io_data_out <= '0;
      grant_id    <= '0;
      abort_pulse <= 1'b0;
    end else begin
      beat_cnt    <= beat_nx;
      stall_cnt   <= stall_nx;
      abort_pulse <= stall_hit;
      io_en_out   <= xfer;
      if (xfer) begin
        io_addr_out <= req_addr[xfer_idx];
        io_data_out <= req_data[xfer_idx];
        last_owner  <= xfer_idx;
        grant_id    <= xfer_idx;
      end
    end
  end

endmodule

// File: tb/tb_io_wr_arbiter.sv
// Randomized and directed bench for io_wr_arbiter against a transaction-level
// model of the grant/burst/stall rules.
module tb_io_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 16;
  localparam int DW    = 256;
  localparam int MAXB  = 8;
  localparam int STALL = 15;

  logic                      clk;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_last;
  logic [NREQ-1:0][AW-1:0]   req_addr;
  logic [NREQ-1:0][DW-1:0]   req_data;
  logic                      io_en_out;
  logic [AW-1:0]             io_addr_out;
  logic [DW-1:0]             io_data_out;
  logic [1:0]                grant_id;
  logic                      abort_pulse;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_log[$];
  int acc_cyc[$];

  // Model: burst owner (-1 = none), last winner, beats this grant, idle run.
  int mdl_owner = -1;
  int mdl_last  = NREQ - 1;
  int mdl_beats = 0;
  int mdl_idle  = 0;
  logic            exp_en    = 1'b0;
  logic [AW-1:0]   exp_addr  = '0;
  logic [DW-1:0]   exp_data  = '0;
  int              exp_gid   = 0;
  logic            exp_abort = 1'b0;
  logic [NREQ-1:0] exp_ready;

  io_wr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_last    (req_last),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .io_en_out   (io_en_out),
    .io_addr_out (io_addr_out),
    .io_data_out (io_data_out),
    .grant_id    (grant_id),
    .abort_pulse (abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic r);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = AW'($urandom);
      for (int j = 0; j < DW / 32; j++) req_data[i][j*32 +: 32] = $urandom;
    end
  endtask

  function automatic int logAt(input int i);
    if (i >= 0 && i < acc_log.size()) return acc_log[i];
    return -1;
  endfunction

  function automatic int cycAt(input int i);
    if (i >= 0 && i < acc_cyc.size()) return acc_cyc[i];
    return -1;
  endfunction

  // Compare process: inputs settle at negedge, check 1 time unit later,
  // then advance the model to what the coming rising edge must produce.
  always @(negedge clk) begin
    int acc;
    int c;
    #1;
    cyc++;
    exp_ready = '0;
    if (!rst) begin
      if (mdl_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (mdl_last + k) % NREQ;
          if (req_valid[c] && exp_ready == '0) exp_ready[c] = 1'b1;
        end
      end else begin
        exp_ready[mdl_owner] = req_valid[mdl_owner];
      end
    end
    checkOutput("req_ready",   DW'(req_ready),   DW'(exp_ready));
    checkOutput("io_en_out",   DW'(io_en_out),   DW'(exp_en));
    checkOutput("io_addr_out", DW'(io_addr_out), DW'(exp_addr));
    checkOutput("io_data_out", io_data_out,      exp_data);
    checkOutput("grant_id",    DW'(grant_id),    DW'(exp_gid));
    checkOutput("abort_pulse", DW'(abort_pulse), DW'(exp_abort));

    if (rst) begin
      mdl_owner = -1; mdl_last = NREQ - 1; mdl_beats = 0; mdl_idle = 0;
      exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = 0; exp_abort = 1'b0;
    end else begin
      acc = -1;
      for (int i = 0; i < NREQ; i++) if (exp_ready[i]) acc = i;
      exp_abort = 1'b0;
      if (acc >= 0) begin
        exp_en   = 1'b1;
        exp_addr = req_addr[acc];
        exp_data = req_data[acc];
        exp_gid  = acc;
        mdl_last = acc;
        acc_log.push_back(acc);
        acc_cyc.push_back(cyc);
        mdl_beats = (mdl_owner < 0) ? 1 : mdl_beats + 1;
        mdl_owner = acc;
        mdl_idle  = 0;
        if (req_last[acc] || mdl_beats == MAXB) begin
          mdl_owner = -1;
          mdl_beats = 0;
        end
      end else begin
        exp_en = 1'b0;
        if (mdl_owner >= 0) begin
          mdl_idle++;
          if (mdl_idle == STALL) begin
            exp_abort = 1'b1;
            mdl_owner = -1;
            mdl_idle  = 0;
            mdl_beats = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    #2;
    checkOutput("reset_ready", DW'(req_ready), DW'(0));
    checkOutput("reset_en",    DW'(io_en_out), DW'(0));
    checkOutput("reset_gid",   DW'(grant_id),  DW'(0));
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Single beat from requester 0
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    req_addr[0] = 16'h0010;
    #2;
    checkOutput("single_ready", DW'(req_ready), DW'(4'b0001));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    checkOutput("single_en",   DW'(io_en_out),   DW'(1));
    checkOutput("single_addr", DW'(io_addr_out), DW'(16'h0010));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    checkOutput("single_idle_en", DW'(io_en_out), DW'(0));

    // Fairness with everyone sending 1-beat bursts, from a fresh reset
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    base = acc_log.size();
    for (int k = 0; k < 8; k++) applyStimulus(4'b1111, 4'b1111, 1'b0);
    #2;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("fair_order%0d", k), DW'(logAt(base + k)), DW'(k % 4));
    checkOutput("fair_en", DW'(io_en_out), DW'(1));
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Burst cap: requester 2 never sets last, requester 3 waiting
    base = acc_log.size();
    for (int k = 0; k < 10; k++) applyStimulus(4'b1100, 4'b1000, 1'b0);
    applyStimulus(4'b1100, 4'b1100, 1'b0);
    #2;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("cap_beat%0d", k), DW'(logAt(base + k)), DW'(2));
    checkOutput("cap_handoff", DW'(logAt(base + 8)),  DW'(3));
    checkOutput("cap_resume",  DW'(logAt(base + 9)),  DW'(2));
    checkOutput("cap_resume2", DW'(logAt(base + 10)), DW'(2));
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Stall abort: owner 1 sends two beats then goes quiet
    base = acc_log.size();
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    for (int k = 0; k < STALL; k++) applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    checkOutput("stall_owner",    DW'(logAt(base)), DW'(1));
    checkOutput("stall_no_early", DW'(abort_pulse), DW'(0));
    applyStimulus(4'b0110, 4'b0110, 1'b0);
    #2;
    checkOutput("stall_abort", DW'(abort_pulse),              DW'(1));
    checkOutput("stall_next",  DW'(logAt(acc_log.size() - 1)), DW'(2));
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Reset during beat 3 of a requester-3 burst
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    #2;
    checkOutput("rst_ready_low", DW'(req_ready), DW'(0));
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    #2;
    checkOutput("rst_en",    DW'(io_en_out),   DW'(0));
    checkOutput("rst_addr",  DW'(io_addr_out), DW'(0));
    checkOutput("rst_data",  io_data_out,      DW'(0));
    checkOutput("rst_gid",   DW'(grant_id),    DW'(0));
    checkOutput("rst_first", DW'(req_ready),   DW'(4'b0001));
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Back-to-back: requester 0 ends, requester 1 accepted the next cycle
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0011, 4'b0001, 1'b0);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    #2;
    base = acc_log.size();
    checkOutput("b2b_prev",  DW'(logAt(base - 2)), DW'(0));
    checkOutput("b2b_next",  DW'(logAt(base - 1)), DW'(1));
    checkOutput("b2b_gap",   DW'(cycAt(base - 1) - cycAt(base - 2)), DW'(1));
    checkOutput("b2b_en_t",  DW'(io_en_out), DW'(1));
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    checkOutput("b2b_en_t1", DW'(io_en_out), DW'(1));

    // Random traffic: busy mix, then sparse valids to provoke stall aborts
    for (int k = 0; k < 300; k++)
      applyStimulus(NREQ'($urandom) | NREQ'($urandom), NREQ'($urandom) & NREQ'($urandom),
                    ($urandom_range(0, 99) == 0));
    for (int k = 0; k < 300; k++) begin
      logic [NREQ-1:0] v;
      v = '0;
      for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 99) < 8);
      applyStimulus(v, NREQ'($urandom), ($urandom_range(0, 199) == 0));
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
